// File: rtl/fetch_sequencer.sv
// IF-stage control FSM: owns the PC register and steers the PC adder through fetch wait, stall, branch flush and HALT.
// Optional macro BRANCH_CNT_EN adds a saturating count of taken-branch redirects on port branch_cnt.
module fetch_sequencer #(
  parameter int                         INST_ADDR_WIDTH = 16,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_VECTOR    = '0,
  parameter int                         FLUSH_CYCLES    = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [INST_ADDR_WIDTH-1:0] pc_next,
  input  logic                       imem_ready,
  input  logic                       stall,
  input  logic                       branch_taken,
  input  logic [INST_ADDR_WIDTH-1:0] branch_target,
  input  logic                       halt_inst,
  input  logic                       resume,
  output logic [INST_ADDR_WIDTH-1:0] pc,
  output logic                       pc_halt,
  output logic                       pc_src,
  output logic [INST_ADDR_WIDTH-1:0] branch_addr,
  output logic                       fetch_req,
  output logic                       if_flush,
  output logic                       halted,
  output logic [1:0]                 state
`ifdef BRANCH_CNT_EN
  ,
  output logic [15:0]                branch_cnt
`endif
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

  logic [1:0] state_next;
  logic [1:0] flush_cnt;
  logic       br_pend;
  logic       last_flush;
  logic       take_branch;

  // Only RUN and WAIT accept a branch; during FLUSH the older branch wins.
  assign take_branch = branch_taken && ((state == ST_RUN) || (state == ST_WAIT));
  assign last_flush  = (state == ST_FLUSH) && (flush_cnt == 2'd0);

  assign fetch_req = (state == ST_RUN) || (state == ST_WAIT);
  assign halted    = (state == ST_HALT);
  assign if_flush  = (state == ST_FLUSH);
  assign pc_src    = last_flush && br_pend;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    pc_halt    = 1'b1;
    unique case (state)
      ST_RUN: begin
        if (branch_taken) begin
          state_next = ST_FLUSH;
        end else if (!stall) begin
          if (halt_inst)        state_next = ST_HALT;
          else if (!imem_ready) state_next = ST_WAIT;
          else                  pc_halt    = 1'b0;
        end
      end
      ST_WAIT: begin
        if (branch_taken) begin
          state_next = ST_FLUSH;
        end else if (imem_ready) begin
          state_next = ST_RUN;
          pc_halt    = stall;
        end
      end
      ST_FLUSH: begin
        // The redirect lands regardless of stall or imem_ready.
        if (flush_cnt == 2'd0) begin
          state_next = ST_RUN;
          pc_halt    = 1'b0;
        end
      end
      ST_HALT: begin
        if (resume) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
    // Keep the adder holding while reset is asserted.
    if (!rst_n) pc_halt = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      pc          <= RESET_VECTOR;
      branch_addr <= '0;
      br_pend     <= 1'b0;
      flush_cnt   <= 2'd0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (take_branch) begin
        branch_addr <= {branch_target[INST_ADDR_WIDTH-1:1], 1'b0};
        br_pend     <= 1'b1;
        flush_cnt   <= FLUSH_LAST;
      end else if (state == ST_FLUSH) begin
        if (flush_cnt != 2'd0) flush_cnt <= flush_cnt - 2'd1;
        else                   br_pend   <= 1'b0;
      end
    end
  end

`ifdef BRANCH_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt <= 16'd0;
    end else if (last_flush && (branch_cnt != 16'hFFFF)) begin
      branch_cnt <= branch_cnt + 16'd1;
    end
  end
`endif

endmodule
